// File: rtl/bloom_store.sv
// Counting Bloom filter storage: saturating per-position counters with check/insert/remove/clear.
// Latency: one cycle from accept to resp_valid/hit; clear takes bl_size cycles before its response.
// Backpressure: ready is low only during the clear sweep; op_valid while not ready is dropped.
module bloom_store #(
    parameter int bl_size = 32,
    parameter int cnt_w   = 4,
    parameter int ecnt_w  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [1:0]         op,
    input  logic [bl_size-1:0] mask,
    output logic               ready,
    output logic               resp_valid,
    output logic               hit,
    output logic [ecnt_w-1:0]  elem_count,
    output logic               sat_flag
);
    localparam int iw = (bl_size > 1) ? $clog2(bl_size) : 1;
    localparam logic [cnt_w-1:0]  cnt_max  = '1;
    localparam logic [ecnt_w-1:0] ecnt_max = '1;
    localparam logic [iw-1:0]     last_idx = iw'(bl_size - 1);

    localparam logic [1:0] OP_CHECK  = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_REMOVE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [cnt_w-1:0] cnt_q [bl_size];
    logic [iw-1:0]    idx_q;
    logic             sweep_done;
    logic             all_pos;
    logic             member;

    // A zero mask has no positions to test, so it is never a member.
    always_comb begin
        all_pos = 1'b1;
        for (int i = 0; i < bl_size; i++) begin
            if (mask[i] && cnt_q[i] == '0) all_pos = 1'b0;
        end
        member = (|mask) && all_pos;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        sweep_done = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (op_valid && op == OP_CLEAR) state_d = CLEAR;
            end
            CLEAR: begin
                if (idx_q == last_idx) begin
                    sweep_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < bl_size; i++) cnt_q[i] <= '0;
            idx_q      <= '0;
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            elem_count <= '0;
            sat_flag   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            if (state_q == IDLE) begin
                if (op_valid) begin
                    case (op)
                        OP_CHECK: begin
                            resp_valid <= 1'b1;
                            hit        <= member;
                        end
                        OP_INSERT: begin
                            resp_valid <= 1'b1;
                            hit        <= member;
                            if (|mask) begin
                                for (int i = 0; i < bl_size; i++) begin
                                    if (mask[i]) begin
                                        if (cnt_q[i] == cnt_max) sat_flag <= 1'b1;
                                        else                     cnt_q[i] <= cnt_q[i] + 1'b1;
                                    end
                                end
                                if (elem_count != ecnt_max) elem_count <= elem_count + 1'b1;
                            end
                        end
                        OP_REMOVE: begin
                            resp_valid <= 1'b1;
                            hit        <= member;
                            if (member) begin
                                // Saturated counters have lost their true count and stay stuck.
                                for (int i = 0; i < bl_size; i++) begin
                                    if (mask[i] && cnt_q[i] != cnt_max) cnt_q[i] <= cnt_q[i] - 1'b1;
                                end
                                if (elem_count != '0) elem_count <= elem_count - 1'b1;
                            end
                        end
                        default: idx_q <= '0;
                    endcase
                end
            end else begin
                cnt_q[idx_q] <= '0;
                if (sweep_done) begin
                    resp_valid <= 1'b1;
                    elem_count <= '0;
                    sat_flag   <= 1'b0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bloom_store.sv
// Directed bench for bloom_store: behavioural filter model checked every cycle plus literal expectations.
module tb_bloom_store;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] mask = '0;
    logic        ready, resp_valid, hit, sat_flag;
    logic [7:0]  elem_count;

    bloom_store #(.bl_size(32), .cnt_w(4), .ecnt_w(8)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .mask(mask),
        .ready(ready), .resp_valid(resp_valid), .hit(hit),
        .elem_count(elem_count), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic lit(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integer counters, a clear countdown, expected response.
    int m_cnt [32];
    int m_elem = 0;
    int m_sat = 0;
    int clr_left = 0;
    int exp_resp = 0;
    int exp_hit = 0;

    function automatic int is_member(input logic [31:0] m);
        if (m == 0) return 0;
        for (int i = 0; i < 32; i++) if (m[i] && m_cnt[i] == 0) return 0;
        return 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_elem = 0; m_sat = 0; clr_left = 0; exp_resp = 0; exp_hit = 0;
        end else begin
            int mem;
            exp_resp = 0;
            exp_hit  = 0;
            if (clr_left > 0) begin
                m_cnt[32 - clr_left] = 0;
                clr_left--;
                if (clr_left == 0) begin
                    exp_resp = 1; m_elem = 0; m_sat = 0;
                end
            end else if (op_valid) begin
                mem = is_member(mask);
                case (op)
                    2'b00: begin exp_resp = 1; exp_hit = mem; end
                    2'b01: begin
                        exp_resp = 1; exp_hit = mem;
                        if (mask != 0) begin
                            for (int i = 0; i < 32; i++)
                                if (mask[i]) begin
                                    if (m_cnt[i] == 15) m_sat = 1;
                                    else m_cnt[i] = m_cnt[i] + 1;
                                end
                            if (m_elem < 255) m_elem++;
                        end
                    end
                    2'b10: begin
                        exp_resp = 1; exp_hit = mem;
                        if (mem == 1) begin
                            for (int i = 0; i < 32; i++)
                                if (mask[i] && m_cnt[i] < 15) m_cnt[i] = m_cnt[i] - 1;
                            if (m_elem > 0) m_elem--;
                        end
                    end
                    default: clr_left = 32;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            lit("cyc_ready", int'(ready), (clr_left == 0) ? 1 : 0);
            lit("cyc_resp_valid", int'(resp_valid), exp_resp);
            lit("cyc_hit", int'(hit), exp_hit);
            lit("cyc_elem_count", int'(elem_count), m_elem);
            lit("cyc_sat_flag", int'(sat_flag), m_sat);
        end
    end

    // Called at a negedge; the response is visible at the following negedge.
    task automatic op1(input logic [1:0] o, input logic [31:0] m, input int exp_h, input string name);
        op_valid = 1'b1; op = o; mask = m;
        @(negedge clk);
        op_valid = 1'b0;
        lit({name, "_resp"}, int'(resp_valid), 1);
        lit({name, "_hit"}, int'(hit), exp_h);
    endtask

    task automatic do_reset(input string name);
        #2 reset = 1'b0;
        #1;
        lit({name, "_ready"}, int'(ready), 1);
        lit({name, "_resp"}, int'(resp_valid), 0);
        lit({name, "_hit"}, int'(hit), 0);
        lit({name, "_elem"}, int'(elem_count), 0);
        lit({name, "_sat"}, int'(sat_flag), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int low_cnt;
        #1 reset = 1'b0;
        chk_en = 1'b1;
        #2;
        lit("rst_ready", int'(ready), 1);
        lit("rst_resp", int'(resp_valid), 0);
        lit("rst_elem", int'(elem_count), 0);
        lit("rst_sat", int'(sat_flag), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Empty filter never hits.
        op1(2'b00, 32'h0000_0111, 0, "chk_empty");
        lit("chk_empty_elem", int'(elem_count), 0);

        // Back-to-back insert then check.
        op_valid = 1'b1; op = 2'b01; mask = 32'h0000_0111;
        @(negedge clk);
        lit("b2b_ins_resp", int'(resp_valid), 1);
        lit("b2b_ins_hit", int'(hit), 0);
        op = 2'b00;
        @(negedge clk);
        op_valid = 1'b0;
        lit("b2b_chk_resp", int'(resp_valid), 1);
        lit("b2b_chk_hit", int'(hit), 1);
        lit("b2b_elem", int'(elem_count), 1);
        op1(2'b00, 32'h0000_0113, 0, "chk_partial");

        // Saturation and stuck counters.
        do_reset("rst2");
        for (int k = 0; k < 16; k++) begin
            op1(2'b01, 32'h8000_0001, (k == 0) ? 0 : 1, "sat_ins");
            if (k == 14) lit("sat_before", int'(sat_flag), 0);
        end
        lit("sat_after", int'(sat_flag), 1);
        lit("sat_elem", int'(elem_count), 16);
        op1(2'b10, 32'h8000_0001, 1, "stuck_rem");
        op1(2'b00, 32'h8000_0001, 1, "stuck_chk");
        lit("stuck_elem", int'(elem_count), 15);

        // Remove past membership.
        do_reset("rst3");
        op1(2'b01, 32'h0000_0006, 0, "ins6_a");
        op1(2'b01, 32'h0000_0006, 1, "ins6_b");
        op1(2'b10, 32'h0000_0006, 1, "rem6_a");
        op1(2'b10, 32'h0000_0006, 1, "rem6_b");
        op1(2'b10, 32'h0000_0006, 0, "rem6_c");
        lit("rem6_elem", int'(elem_count), 0);
        op1(2'b00, 32'h0000_0006, 0, "chk6");
        op1(2'b01, 32'h0000_0000, 0, "ins_zero");
        lit("ins_zero_elem", int'(elem_count), 0);

        // Clear sweep with ignored requests.
        op1(2'b01, 32'h0000_0111, 0, "pre_clr_a");
        op1(2'b01, 32'h8000_0001, 0, "pre_clr_b");
        op1(2'b01, 32'h0000_0006, 0, "pre_clr_c");
        lit("pre_clr_elem", int'(elem_count), 3);
        op_valid = 1'b1; op = 2'b11; mask = '0;
        @(negedge clk);
        op_valid = 1'b0;
        low_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (ready) break;
            low_cnt++;
            op_valid = (k % 3 == 0); op = 2'b01; mask = 32'h0000_0111;
            @(negedge clk);
        end
        op_valid = 1'b0;
        lit("clr_low_cycles", low_cnt, 32);
        lit("clr_resp", int'(resp_valid), 1);
        lit("clr_hit", int'(hit), 0);
        lit("clr_elem", int'(elem_count), 0);
        lit("clr_sat", int'(sat_flag), 0);
        op1(2'b00, 32'h0000_0111, 0, "post_clr_a");
        op1(2'b00, 32'h8000_0001, 0, "post_clr_b");
        op1(2'b00, 32'h0000_0006, 0, "post_clr_c");

        // Reset in the middle of a sweep.
        op1(2'b01, 32'h0000_0111, 0, "mid_ins");
        op_valid = 1'b1; op = 2'b11;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (10) @(negedge clk);
        lit("mid_ready_low", int'(ready), 0);
        do_reset("mid_rst");
        lit("mid_no_resp", int'(resp_valid), 0);
        op1(2'b00, 32'h0000_0111, 0, "mid_chk");
        lit("mid_elem", int'(elem_count), 0);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
